// File: rtl/grant_sequencer.sv
// -----------------------------------------------------------------------------
// grant_sequencer
// Takes one grant from a 4-way round-robin arbiter and plays the owner's burst
// onto a shared valid/ready bus. After each burst it idles for GAP turnaround
// cycles, then it returns to IDLE so that it can accept a new grant.
//
// Ports
//   clk                  sole clock, rising edge
//   rst                  asynchronous active-low reset
//   gnt3..gnt0           arbiter grant lines (one-hot or zero)
//   din0..din3           current data word of each requester
//   bl0..bl3             burst length per requester (beats = bl+1)
//   bus_ready            downstream accepts the beat offered this cycle
//   bus_valid            a beat is present on the bus
//   bus_data/id/last     beat payload, owner index, final-beat flag (0 when idle)
//   ack3..ack0           combinational: the owner's beat is accepted this cycle
//   done3..done0         registered one-cycle pulse after the owner's last beat
//   busy                 high whenever the sequencer is not in IDLE
//   err                  sticky: more than one grant was seen in IDLE
// -----------------------------------------------------------------------------
module grant_sequencer #(
    parameter int DW  = 8,
    parameter int GAP = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          gnt3,
    input  logic          gnt2,
    input  logic          gnt1,
    input  logic          gnt0,
    input  logic [DW-1:0] din0,
    input  logic [DW-1:0] din1,
    input  logic [DW-1:0] din2,
    input  logic [DW-1:0] din3,
    input  logic [1:0]    bl0,
    input  logic [1:0]    bl1,
    input  logic [1:0]    bl2,
    input  logic [1:0]    bl3,
    input  logic          bus_ready,
    output logic          bus_valid,
    output logic [DW-1:0] bus_data,
    output logic [1:0]    bus_id,
    output logic          bus_last,
    output logic          ack3,
    output logic          ack2,
    output logic          ack1,
    output logic          ack0,
    output logic          done3,
    output logic          done2,
    output logic          done1,
    output logic          done0,
    output logic          busy,
    output logic          err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        TURN = 2'd2
    } state_t;

    localparam logic [1:0] GAP_L = 2'(GAP);

    state_t        state_r, state_s;
    logic [1:0]    id_r, id_s;
    logic [2:0]    cnt_r, cnt_s;
    logic [1:0]    gap_r, gap_s;
    logic [3:0]    done_r, done_s;
    logic          err_r, err_s;

    logic [3:0]    gnt_s;
    logic [1:0]    gnt_idx_s;
    logic [1:0]    bl_sel_s;
    logic [DW-1:0] data_sel_s;
    logic          valid_s;
    logic          accept_s;
    logic          last_s;

    // Number of asserted grant lines.
    function automatic logic [2:0] count_grants(input logic [3:0] g);
        count_grants = {2'b00, g[0]} + {2'b00, g[1]} + {2'b00, g[2]} + {2'b00, g[3]};
    endfunction

    assign gnt_s    = {gnt3, gnt2, gnt1, gnt0};
    assign valid_s  = (state_r == XFER);
    assign accept_s = valid_s & bus_ready;
    assign last_s   = valid_s & (cnt_r == 3'd1);

    // Encode the one-hot grant and pick that requester's burst length.
    always_comb begin
        gnt_idx_s = 2'd0;
        bl_sel_s  = bl0;
        case (gnt_s)
            4'b0001: begin gnt_idx_s = 2'd0; bl_sel_s = bl0; end
            4'b0010: begin gnt_idx_s = 2'd1; bl_sel_s = bl1; end
            4'b0100: begin gnt_idx_s = 2'd2; bl_sel_s = bl2; end
            4'b1000: begin gnt_idx_s = 2'd3; bl_sel_s = bl3; end
            default: begin gnt_idx_s = 2'd0; bl_sel_s = bl0; end
        endcase
    end

    // Live data of the captured owner; bus_data follows it even while stalled.
    always_comb begin
        data_sel_s = din0;
        case (id_r)
            2'd0:    data_sel_s = din0;
            2'd1:    data_sel_s = din1;
            2'd2:    data_sel_s = din2;
            2'd3:    data_sel_s = din3;
            default: data_sel_s = din0;
        endcase
    end

    // Next-state logic for IDLE / XFER / TURN.
    always_comb begin
        state_s = state_r;
        id_s    = id_r;
        cnt_s   = cnt_r;
        gap_s   = gap_r;
        err_s   = err_r;
        done_s  = 4'b0000;
        case (state_r)
            IDLE: begin
                if (count_grants(gnt_s) == 3'd1) begin
                    state_s = XFER;
                    id_s    = gnt_idx_s;
                    cnt_s   = {1'b0, bl_sel_s} + 3'd1;
                end else if (count_grants(gnt_s) > 3'd1) begin
                    err_s   = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            XFER: begin
                if (accept_s) begin
                    cnt_s = cnt_r - 3'd1;
                    if (last_s) begin
                        done_s = 4'b0001 << id_r;
                        if (GAP > 0) begin
                            state_s = TURN;
                            // TURN lasts GAP cycles including the entry cycle.
                            gap_s   = GAP_L - 2'd1;
                        end else begin
                            state_s = IDLE;
                        end
                    end else begin
                        state_s = XFER;
                    end
                end else begin
                    state_s = XFER;
                end
            end
            TURN: begin
                if (gap_r == 2'd0) begin
                    state_s = IDLE;
                end else begin
                    gap_s = gap_r - 2'd1;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, owner, counters and sticky error register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
            id_r    <= 2'd0;
            cnt_r   <= 3'd0;
            gap_r   <= 2'd0;
            done_r  <= 4'b0000;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            id_r    <= id_s;
            cnt_r   <= cnt_s;
            gap_r   <= gap_s;
            done_r  <= done_s;
            err_r   <= err_s;
        end
    end

    assign bus_valid = valid_s;
    assign bus_id    = valid_s ? id_r : 2'd0;
    assign bus_last  = last_s;
    assign bus_data  = valid_s ? data_sel_s : {DW{1'b0}};
    assign ack0      = accept_s & (id_r == 2'd0);
    assign ack1      = accept_s & (id_r == 2'd1);
    assign ack2      = accept_s & (id_r == 2'd2);
    assign ack3      = accept_s & (id_r == 2'd3);
    assign done0     = done_r[0];
    assign done1     = done_r[1];
    assign done2     = done_r[2];
    assign done3     = done_r[3];
    assign busy      = (state_r != IDLE);
    assign err       = err_r;

endmodule

// File: tb/tb_grant_sequencer.sv
// -----------------------------------------------------------------------------
// tb_grant_sequencer
// Drives a GAP=0 and a GAP=1 instance of grant_sequencer with identical inputs
// and compares every output once per cycle against a transaction-level model
// (owner / beats remaining / turnaround cycles remaining). Directed sequences
// cover the burst scenarios of interest, then random traffic follows.
// -----------------------------------------------------------------------------
module tb_grant_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] gnt;
    logic       rdy;
    logic [7:0] din [4];
    logic [1:0] bl  [4];
    logic [7:0] set_din [4];
    logic [1:0] set_bl  [4];

    logic       v0, v1, last0, last1, busy0, busy1, err0, err1;
    logic [1:0] id0, id1;
    logic [7:0] dat0, dat1;
    logic [3:0] ack0, ack1, dn0, dn1;
    logic [21:0] obs0, obs1;

    int n_total = 0;
    int n_pass  = 0;

    // Model state per instance (index = GAP value).
    int own [2];
    int rem [2];
    int cool [2];
    int dpend [2];
    bit merr [2];

    always #5 clk = ~clk;

    grant_sequencer #(.DW(8), .GAP(0)) u_gap0 (
        .clk(clk), .rst(rst),
        .gnt3(gnt[3]), .gnt2(gnt[2]), .gnt1(gnt[1]), .gnt0(gnt[0]),
        .din0(din[0]), .din1(din[1]), .din2(din[2]), .din3(din[3]),
        .bl0(bl[0]), .bl1(bl[1]), .bl2(bl[2]), .bl3(bl[3]),
        .bus_ready(rdy), .bus_valid(v0), .bus_data(dat0), .bus_id(id0),
        .bus_last(last0),
        .ack3(ack0[3]), .ack2(ack0[2]), .ack1(ack0[1]), .ack0(ack0[0]),
        .done3(dn0[3]), .done2(dn0[2]), .done1(dn0[1]), .done0(dn0[0]),
        .busy(busy0), .err(err0)
    );

    grant_sequencer #(.DW(8), .GAP(1)) u_gap1 (
        .clk(clk), .rst(rst),
        .gnt3(gnt[3]), .gnt2(gnt[2]), .gnt1(gnt[1]), .gnt0(gnt[0]),
        .din0(din[0]), .din1(din[1]), .din2(din[2]), .din3(din[3]),
        .bl0(bl[0]), .bl1(bl[1]), .bl2(bl[2]), .bl3(bl[3]),
        .bus_ready(rdy), .bus_valid(v1), .bus_data(dat1), .bus_id(id1),
        .bus_last(last1),
        .ack3(ack1[3]), .ack2(ack1[2]), .ack1(ack1[1]), .ack0(ack1[0]),
        .done3(dn1[3]), .done2(dn1[2]), .done1(dn1[1]), .done0(dn1[0]),
        .busy(busy1), .err(err1)
    );

    assign obs0 = {v0, id0, last0, ack0, dn0, busy0, err0, dat0};
    assign obs1 = {v1, id1, last1, ack1, dn1, busy1, err1, dat1};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got === want) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h want %h (t=%0t)", tag, got, want, $time);
        end
    endtask

    function automatic logic [21:0] exp_vec(int k);
        logic       valid;
        logic [1:0] idv;
        logic [3:0] a;
        logic [3:0] d;
        logic [7:0] dv;
        logic       b;
        logic       lst;
        valid = (own[k] >= 0);
        idv   = valid ? 2'(own[k]) : 2'd0;
        a     = (valid && rdy) ? (4'b0001 << own[k]) : 4'b0000;
        d     = (dpend[k] >= 0) ? (4'b0001 << dpend[k]) : 4'b0000;
        dv    = valid ? din[own[k]] : 8'h00;
        b     = valid || (cool[k] > 0);
        lst   = valid && (rem[k] == 1);
        return {valid, idv, lst, a, d, b, merr[k], dv};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            own[k] = -1; rem[k] = 0; cool[k] = 0; dpend[k] = -1; merr[k] = 1'b0;
        end
    endtask

    // What happens to instance k (GAP=k) at the coming rising edge.
    task automatic model_edge(input int k);
        int ng;
        int idx;
        ng  = $countones(gnt);
        idx = 0;
        for (int i = 0; i < 4; i++) if (gnt[i]) idx = i;
        dpend[k] = -1;
        if (own[k] >= 0) begin
            if (rdy) begin
                rem[k]--;
                if (rem[k] == 0) begin
                    dpend[k] = own[k];
                    own[k]   = -1;
                    cool[k]  = k;
                end
            end
        end else if (cool[k] > 0) begin
            cool[k]--;
        end else if (ng == 1) begin
            own[k] = idx;
            rem[k] = int'(bl[idx]) + 1;
        end else if (ng > 1) begin
            merr[k] = 1'b1;
        end
    endtask

    // One clock cycle: apply inputs on the falling edge, check, advance model.
    task automatic step(input logic [3:0] g, input logic r);
        @(negedge clk);
        gnt = g;
        rdy = r;
        din = set_din;
        bl  = set_bl;
        #1;
        chk("gap0_outputs", 32'(obs0), 32'(exp_vec(0)));
        chk("gap1_outputs", 32'(obs1), 32'(exp_vec(1)));
        model_edge(0);
        model_edge(1);
    endtask

    task automatic do_reset();
        #1 rst = 1'b0;
        #1;
        chk("rst_gap0_zero", 32'(obs0), 32'd0);
        chk("rst_gap1_zero", 32'(obs1), 32'd0);
        model_reset();
        gnt = 4'b0000;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic rand_cycle(input bit allow_multi);
        int r;
        logic [3:0] g;
        r = int'($urandom_range(0, 9));
        if (r < 5) g = 4'b0000;
        else if (r < 9 || !allow_multi) g = 4'b0001 << $urandom_range(0, 3);
        else g = 4'b0011 << $urandom_range(0, 2);
        for (int i = 0; i < 4; i++) begin
            set_din[i] = 8'($urandom);
            set_bl[i]  = 2'($urandom);
        end
        step(g, ($urandom_range(0, 3) != 0));
    endtask

    initial begin
        int acnt;
        int dcnt;
        logic rseq [7];
        rseq = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        rst = 1'b0;
        gnt = 4'b0000;
        rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_din[i] = 8'h00; set_bl[i] = 2'd0; din[i] = 8'h00; bl[i] = 2'd0;
        end
        model_reset();
        #3;
        chk("por_gap0_zero", 32'(obs0), 32'd0);
        chk("por_gap1_zero", 32'(obs1), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Single-beat burst from requester 0.
        set_din[0] = 8'hA5; set_bl[0] = 2'd0;
        step(4'b0001, 1'b1);
        step(4'b0000, 1'b1);
        chk("a5_valid", 32'(v1), 32'd1);
        chk("a5_data", 32'(dat1), 32'hA5);
        chk("a5_last", 32'(last1), 32'd1);
        chk("a5_ack0", 32'(ack1), 32'h1);
        step(4'b0000, 1'b1);
        chk("a5_done0", 32'(dn1), 32'h1);
        chk("a5_turn_busy", 32'(busy1), 32'd1);
        step(4'b0000, 1'b1);
        chk("a5_idle", 32'(busy1), 32'd0);

        // Four-beat burst from requester 2 with one stall.
        set_bl[2] = 2'd3;
        step(4'b0100, 1'b1);
        acnt = 0;
        dcnt = 0;
        for (int i = 0; i < 7; i++) begin
            set_din[2] = 8'($urandom);
            step(4'b0000, rseq[i]);
            acnt += int'(ack1[2]);
            dcnt += int'(dn1[2]);
        end
        chk("b4_ack2_count", 32'(acnt), 32'd4);
        chk("b4_done2_count", 32'(dcnt), 32'd1);

        // Owner's burst length and competing grants ignored mid-burst.
        set_bl[0] = 2'd3;
        step(4'b0001, 1'b1);
        set_bl[0] = 2'd0;
        for (int i = 0; i < 5; i++) step(4'b0010, 1'b1);
        step(4'b0000, 1'b1);
        step(4'b0000, 1'b1);

        // Reset on beat 2 of a 4-beat burst, then a fresh 2-beat burst.
        set_bl[0] = 2'd3;
        step(4'b0001, 1'b1);
        step(4'b0000, 1'b1);
        step(4'b0000, 1'b1);
        do_reset();
        set_bl[3] = 2'd1;
        step(4'b1000, 1'b1);
        step(4'b0000, 1'b1);
        chk("rst_id3", 32'(id1), 32'd3);
        for (int i = 0; i < 4; i++) step(4'b0000, 1'b1);

        // GAP=0 back-to-back bursts: one idle cycle between them.
        set_bl[0] = 2'd0; set_bl[1] = 2'd0;
        step(4'b0001, 1'b1);
        step(4'b0010, 1'b1);
        chk("g0_first_valid", 32'(v0), 32'd1);
        step(4'b0010, 1'b1);
        chk("g0_idle_valid", 32'(v0), 32'd0);
        chk("g0_done0", 32'(dn0), 32'h1);
        step(4'b0000, 1'b1);
        chk("g0_second_valid", 32'(v0), 32'd1);
        chk("g0_second_id", 32'(id0), 32'd1);
        for (int i = 0; i < 3; i++) step(4'b0000, 1'b1);

        // Random traffic without multi-grants.
        for (int i = 0; i < 400; i++) rand_cycle(1'b0);
        for (int i = 0; i < 6; i++) step(4'b0000, 1'b1);

        // Double grant in IDLE: err sticky, nothing captured, then normal burst.
        step(4'b1010, 1'b1);
        step(4'b0000, 1'b1);
        chk("err_set", 32'(err1), 32'd1);
        chk("err_not_busy", 32'(busy1), 32'd0);
        chk("err_no_valid", 32'(v1), 32'd0);
        set_bl[3] = 2'd0;
        step(4'b1000, 1'b1);
        step(4'b0000, 1'b1);
        chk("err_burst_id3", 32'(id1), 32'd3);
        chk("err_still_set", 32'(err1), 32'd1);

        // Random traffic including multi-grants, with a reset in the middle.
        for (int i = 0; i < 300; i++) rand_cycle(1'b1);
        do_reset();
        for (int i = 0; i < 300; i++) rand_cycle(1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
